// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
//   Shared definitions for the fetch side of the core.
//   - ifu_state_e : IFU state encoding (IDLE, AR, R, OUT)
//   - FAULT_*     : instruction fault codes reported alongside inst
//   - RESP_OKAY   : AXI4-Lite read response value meaning success
// -----------------------------------------------------------------------------
package npc_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_AR   = 2'd1,
    IFU_R    = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_ACCESS   = 2'd1;
  localparam logic [1:0] FAULT_MISALIGN = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch unit. Takes the PC from the PC register, issues a single
//   AXI4-Lite-style read (AR then R) to instruction memory and hands the
//   returned instruction to the decoder over a valid/ready handshake. Only one
//   fetch is ever outstanding. Misaligned PCs are reported without a bus
//   access; a redirect (flush) abandons the current fetch or instruction.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   pc, pc_valid             PC to fetch and its qualifier
//   flush                    redirect: abandon current fetch/instruction
//   arvalid/arready/araddr   read address channel
//   rvalid/rready/rdata/rresp read data channel
//   inst_valid/inst_ready    handshake towards the decoder
//   inst, inst_pc, inst_fault instruction, its PC and fault code
// -----------------------------------------------------------------------------
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pc,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              arvalid,
  input  logic              arready,
  output logic [WIDTH-1:0]  araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [IWIDTH-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [IWIDTH-1:0] inst,
  output logic [WIDTH-1:0]  inst_pc,
  output logic [1:0]        inst_fault
);

  ifu_state_e        state_reg;
  logic              drop_reg;       // response of an abandoned fetch still due
  logic [WIDTH-1:0]  araddr_reg;
  logic [IWIDTH-1:0] inst_reg;
  logic [WIDTH-1:0]  inst_pc_reg;
  logic [1:0]        fault_reg;
  logic              inst_valid_reg;

  // The bus handshakes are pure state decodes so the channel opens in the
  // very cycle the state is entered.
  assign arvalid    = (state_reg == IFU_AR);
  assign rready     = (state_reg == IFU_R);
  assign araddr     = araddr_reg;
  assign inst_valid = inst_valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_fault = fault_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IFU_IDLE;
      drop_reg       <= 1'b0;
      araddr_reg     <= '0;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      fault_reg      <= FAULT_NONE;
      inst_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IFU_IDLE: begin
          if (pc_valid && !flush) begin
            inst_pc_reg <= pc;
            if (pc[1:0] != 2'b00) begin
              // Misaligned: report straight away, memory is never touched.
              inst_reg       <= '0;
              fault_reg      <= FAULT_MISALIGN;
              inst_valid_reg <= 1'b1;
              state_reg      <= IFU_OUT;
            end else begin
              araddr_reg <= pc;
              state_reg  <= IFU_AR;
            end
          end
        end

        IFU_AR: begin
          // An AR request cannot be withdrawn once raised, so a flush here
          // only marks the eventual response for discarding.
          if (flush) begin
            drop_reg <= 1'b1;
          end
          if (arready) begin
            state_reg <= IFU_R;
          end
        end

        IFU_R: begin
          if (rvalid) begin
            if (drop_reg || flush) begin
              drop_reg  <= 1'b0;
              state_reg <= IFU_IDLE;
            end else begin
              inst_reg       <= (rresp == RESP_OKAY) ? rdata : '0;
              fault_reg      <= (rresp != RESP_OKAY) ? FAULT_ACCESS : FAULT_NONE;
              inst_valid_reg <= 1'b1;
              state_reg      <= IFU_OUT;
            end
          end else if (flush) begin
            drop_reg <= 1'b1;
          end
        end

        IFU_OUT: begin
          // Flush and a decoder handshake both simply retire the instruction.
          if (flush || inst_ready) begin
            inst_valid_reg <= 1'b0;
            state_reg      <= IFU_IDLE;
          end
        end

        default: state_reg <= IFU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch
//   Directed bench for ifu_fetch. A bus responder emulates instruction memory
//   with programmable AR/R wait states; a transaction-level model (queue of
//   expected instructions derived from the fetch rules) is checked every
//   cycle together with channel-stability rules, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        flush = 1'b0;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic [1:0]  inst_fault;

  int checks = 0;
  int errors = 0;

  // memory responder controls
  int          ar_delay = 0;
  int          r_delay = 0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = 2'b00;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;
  exp_t expq[$];

  ifu_fetch #(.WIDTH(32), .IWIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // What the decoder must eventually see for a fetch that is not abandoned.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] resp);
    exp_t e;
    e.pc = a;
    if (a[1:0] != 2'b00) begin
      e.inst = 32'h0; e.fault = 2'd2;
    end else if (resp != 2'b00) begin
      e.inst = 32'h0; e.fault = 2'd1;
    end else begin
      e.inst = d; e.fault = 2'd0;
    end
    return e;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    bit hs_ar, hs_r, r_pend;
    int ar_cnt, r_cnt;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    r_pend = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      @(posedge clk);
      #1;
      if (rst) begin
        r_pend = 0; ar_cnt = 0; r_cnt = 0; arready = 1'b0; rvalid = 1'b0;
      end else begin
        if (hs_ar) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; end
        if (hs_r) r_pend = 0;
        arready = arvalid && (ar_cnt >= ar_delay);
        if (arvalid && !arready) ar_cnt++;
        if (r_pend && r_cnt >= r_delay) begin
          rvalid = 1'b1; rdata = mem_rdata; rresp = mem_rresp;
        end else begin
          rvalid = 1'b0;
          if (r_pend) r_cnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare process ----------------
  initial begin
    bit          p_ok;
    logic        p_arvalid, p_arready, p_inst_valid, p_inst_ready, p_flush;
    logic [31:0] p_araddr, p_inst, p_inst_pc;
    logic [1:0]  p_fault;
    p_ok = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        p_ok = 0;
      end else begin
        chk("ar_r_exclusive", {31'b0, arvalid & rready}, 32'h0);
        if (inst_valid) chk("out_no_bus", {31'b0, arvalid | rready}, 32'h0);
        if (p_ok && p_arvalid && !p_arready) begin
          chk("arvalid_hold", {31'b0, arvalid}, 32'h1);
          chk("araddr_hold", araddr, p_araddr);
        end
        if (p_ok && p_flush) chk("flush_kills_valid", {31'b0, inst_valid}, 32'h0);
        if (p_ok && p_inst_valid && !p_inst_ready && !p_flush) begin
          chk("inst_valid_hold", {31'b0, inst_valid}, 32'h1);
          chk("inst_hold", inst, p_inst);
          chk("inst_pc_hold", inst_pc, p_inst_pc);
          chk("fault_hold", {30'b0, inst_fault}, {30'b0, p_fault});
        end
        if (inst_valid) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_inst: got inst_valid=1 pc=0x%08h expected no instruction", inst_pc);
          end else begin
            chk("inst", inst, expq[0].inst);
            chk("inst_pc", inst_pc, expq[0].pc);
            chk("inst_fault", {30'b0, inst_fault}, {30'b0, expq[0].fault});
            if (inst_ready || flush) begin
              $display("txn pc=0x%08h inst=0x%08h fault=%0d %s", inst_pc, inst,
                       inst_fault, flush ? "flushed" : "accepted");
              void'(expq.pop_front());
            end
          end
        end
        p_ok = 1;
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        p_inst_valid = inst_valid; p_inst_ready = inst_ready; p_flush = flush;
        p_inst = inst; p_inst_pc = inst_pc; p_fault = inst_fault;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // pc_valid is high for exactly one cycle (cycle 0); returns in cycle 1.
  task automatic start_fetch(input logic [31:0] a);
    pc = a; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with inst_valid; lat counts
  // cycles from the pc_valid cycle.
  task automatic wait_valid(output int lat, output int ar_cycles);
    lat = 1; ar_cycles = 0;
    forever begin
      @(negedge clk);
      if (arvalid) ar_cycles++;
      if (inst_valid) break;
      if (lat >= 40) begin
        checks++; errors++;
        $display("FAIL wait_valid_timeout: got no inst_valid after %0d cycles expected one", lat);
        break;
      end
      cyc();
      lat++;
    end
  endtask

  initial begin
    int lat, arc, rhs, ivc;
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, arc, rhs, ivc;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_arvalid", {31'b0, arvalid}, 0);
    chk("rst_rready", {31'b0, rready}, 0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fault", {30'b0, inst_fault}, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: zero-wait fetch, cycle-exact latency
    mem_rdata = 32'h0000_0413; mem_rresp = 2'b00; inst_ready = 1'b1;
    expq.push_back(model(32'h8000_0000, mem_rdata, mem_rresp));
    pc = 32'h8000_0000; pc_valid = 1'b1;
    @(negedge clk);
    chk("t1_c0_arvalid", {31'b0, arvalid}, 0);
    cyc(); pc_valid = 1'b0;
    @(negedge clk);
    chk("t1_c1_arvalid", {31'b0, arvalid}, 1);
    chk("t1_c1_araddr", araddr, 32'h8000_0000);
    cyc();
    @(negedge clk);
    chk("t1_c2_rready", {31'b0, rready}, 1);
    chk("t1_c2_rvalid", {31'b0, rvalid}, 1);
    chk("t1_c2_inst_valid", {31'b0, inst_valid}, 0);
    cyc();
    @(negedge clk);
    chk("t1_c3_inst_valid", {31'b0, inst_valid}, 1);
    chk("t1_c3_inst", inst, 32'h0000_0413);
    chk("t1_c3_inst_pc", inst_pc, 32'h8000_0000);
    chk("t1_c3_fault", {30'b0, inst_fault}, 0);
    cyc();
    @(negedge clk);
    chk("t1_c4_inst_valid", {31'b0, inst_valid}, 0);
    cyc();

    // 2: AR wait 3, R wait 2, decoder stalls 2 extra cycles
    ar_delay = 3; r_delay = 2; inst_ready = 1'b0; mem_rdata = 32'h00A0_0093;
    expq.push_back(model(32'h8000_0004, mem_rdata, mem_rresp));
    start_fetch(32'h8000_0004);
    wait_valid(lat, arc);
    chk("t2_latency", lat, 8);
    chk("t2_ar_cycles", arc, 4);
    cyc(); cyc();
    cyc(); inst_ready = 1'b1;
    @(negedge clk);
    chk("t2_still_valid", {31'b0, inst_valid}, 1);
    cyc(); inst_ready = 1'b0;
    @(negedge clk);
    chk("t2_after_hs", {31'b0, inst_valid}, 0);
    cyc();
    ar_delay = 0; r_delay = 0; inst_ready = 1'b1;

    // 3: misaligned PC, no bus access
    expq.push_back(model(32'h8000_0002, 32'hDEAD_BEEF, 2'b00));
    start_fetch(32'h8000_0002);
    wait_valid(lat, arc);
    chk("t3_latency", lat, 1);
    chk("t3_ar_cycles", arc, 0);
    chk("t3_inst", inst, 0);
    chk("t3_fault", {30'b0, inst_fault}, 2);
    cyc();

    // 4: access error response
    mem_rdata = 32'hFFFF_FFFF; mem_rresp = 2'b10;
    expq.push_back(model(32'h8000_0008, mem_rdata, mem_rresp));
    start_fetch(32'h8000_0008);
    wait_valid(lat, arc);
    chk("t4_latency", lat, 3);
    chk("t4_inst", inst, 0);
    chk("t4_fault", {30'b0, inst_fault}, 1);
    cyc();
    mem_rresp = 2'b00;

    // 5: flush while AR is stalled; response must be swallowed
    ar_delay = 3; mem_rdata = 32'h1111_1111;
    start_fetch(32'h8000_000C);
    flush = 1'b1;
    arc = 0; rhs = 0; ivc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (arvalid) arc++;
      if (rvalid && rready) rhs++;
      if (inst_valid) ivc++;
      cyc();
      flush = 1'b0;
    end
    chk("t5_ar_cycles", arc, 4);
    chk("t5_r_consumed", rhs, 1);
    chk("t5_no_inst", ivc, 0);
    ar_delay = 0; mem_rdata = 32'h0000_0013;
    expq.push_back(model(32'h8000_0100, mem_rdata, mem_rresp));
    start_fetch(32'h8000_0100);
    wait_valid(lat, arc);
    chk("t5_refetch_latency", lat, 3);
    chk("t5_refetch_inst", inst, 32'h0000_0013);
    cyc();

    // 6a: flush and inst_ready together in OUT
    inst_ready = 1'b0; mem_rdata = 32'h0020_0113;
    expq.push_back(model(32'h8000_0200, mem_rdata, mem_rresp));
    start_fetch(32'h8000_0200);
    cyc(); cyc();
    flush = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", {31'b0, inst_valid}, 1);
    cyc();
    flush = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    chk("t6_flushed_valid", {31'b0, inst_valid}, 0);
    cyc();
    inst_ready = 1'b1; mem_rdata = 32'h0030_0193;
    expq.push_back(model(32'h8000_0300, mem_rdata, mem_rresp));
    start_fetch(32'h8000_0300);
    wait_valid(lat, arc);
    chk("t6_idle_latency", lat, 3);
    cyc();

    // 6b: asynchronous reset while waiting in R
    r_delay = 5;
    start_fetch(32'h8000_0400);
    cyc();
    chk("t6_rready_before_rst", {31'b0, rready}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_rready", {31'b0, rready}, 0);
    chk("t6_rst_arvalid", {31'b0, arvalid}, 0);
    chk("t6_rst_inst_valid", {31'b0, inst_valid}, 0);
    chk("t6_rst_araddr", araddr, 0);
    chk("t6_rst_inst", inst, 0);
    chk("t6_rst_inst_pc", inst_pc, 0);
    cyc();
    rst = 1'b0; r_delay = 0; mem_rdata = 32'h0050_0293;
    cyc();
    expq.push_back(model(32'h8000_0500, mem_rdata, mem_rresp));
    start_fetch(32'h8000_0500);
    wait_valid(lat, arc);
    chk("t6_post_rst_latency", lat, 3);
    chk("t6_post_rst_inst", inst, 32'h0050_0293);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
